volatility_ctrl: RTL and testbench

- Write-address generator for the volatility engine's shared price-history RAM.
- The RAM is split into NUM_STOCKS regions of BUFFER_SIZE words each; each stock's region is used as a circular window.
- On each valid price sample, the block returns the RAM address the sample is written to, then advances that stock's ring pointer.
- Sits between the order-book/price feed and the history RAM write port.

---
 rtl/volatility_ctrl.sv | 154 +++++++++++++++
 tb/tb_volatility_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/volatility_ctrl.sv
// Ring-buffer write-address generator for the shared price-history RAM.
// Optional build macro VOLATILITY_CTRL_FULL_FLAG_EN adds o_window_full with per-stock fill counters.
module volatility_ctrl #(
  parameter int NUM_STOCKS  = 4,
  parameter int BUFFER_SIZE = 20,
  parameter int DATA_WIDTH  = 32,
  localparam int ID_W   = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
  localparam int ADDR_W = (NUM_STOCKS * BUFFER_SIZE > 1) ? $clog2(NUM_STOCKS * BUFFER_SIZE) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [ID_W-1:0]       i_stock_id,
  input  logic                  i_data_valid,
  input  logic [DATA_WIDTH-1:0] i_buffer_size,
  output logic [ADDR_W-1:0]     o_write_address,
`ifdef VOLATILITY_CTRL_FULL_FLAG_EN
  output logic                  o_window_full,
`endif
  output logic                  o_addr_valid
);

  localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int EFF_W = $clog2(BUFFER_SIZE + 1);
  localparam int CMP_W = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;

  logic [CMP_W-1:0]  size_ext;
  logic [EFF_W-1:0]  eff;
  logic [31:0]       id_ext;
  logic              id_ok;
  logic              accept;
  logic [PTR_W-1:0]  ptr_all [NUM_STOCKS];
  logic [PTR_W-1:0]  sel_ptr;
  logic [EFF_W-1:0]  sel_ext;
  logic [EFF_W-1:0]  slot;
  logic              wrap;
  logic [PTR_W-1:0]  ptr_adv;
  logic [ADDR_W-1:0] addr_next;

  logic [ADDR_W-1:0] write_address_reg;
  logic              addr_valid_reg;

  assign size_ext = CMP_W'(i_buffer_size);
  assign id_ext   = 32'(i_stock_id);
  assign id_ok    = (id_ext < 32'(NUM_STOCKS));
  assign accept   = i_data_valid && id_ok;

  // Zero and oversize requests both fall back to the full physical window.
  always_comb begin
    eff = EFF_W'(BUFFER_SIZE);
    if ((size_ext != '0) && (size_ext <= CMP_W'(BUFFER_SIZE))) begin
      eff = EFF_W'(size_ext);
    end
  end

  always_comb begin
    sel_ptr = '0;
    for (int s = 0; s < NUM_STOCKS; s++) begin
      if (id_ext == 32'(s)) begin
        sel_ptr = ptr_all[s];
      end
    end
  end

  // A pointer left beyond a shrunken window restarts at the region base.
  assign sel_ext   = EFF_W'(sel_ptr);
  assign slot      = (sel_ext >= eff) ? '0 : sel_ext;
  assign wrap      = (slot == (eff - EFF_W'(1)));
  assign ptr_adv   = wrap ? '0 : PTR_W'(slot + EFF_W'(1));
  assign addr_next = ADDR_W'(id_ext) * ADDR_W'(BUFFER_SIZE) + ADDR_W'(slot);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STOCKS; gi++) begin : g_stock
      logic             hit;
      logic [PTR_W-1:0] ptr_reg;

      assign hit         = accept && (id_ext == 32'(gi));
      assign ptr_all[gi] = ptr_reg;

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          ptr_reg <= '0;
        end else if (hit) begin
          ptr_reg <= ptr_adv;
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      write_address_reg <= '0;
      addr_valid_reg    <= 1'b0;
    end else begin
      addr_valid_reg <= accept;
      if (accept) begin
        write_address_reg <= addr_next;
      end
    end
  end

  assign o_write_address = write_address_reg;
  assign o_addr_valid    = addr_valid_reg;

`ifdef VOLATILITY_CTRL_FULL_FLAG_EN
  logic [EFF_W-1:0] cnt_all [NUM_STOCKS];
  logic [EFF_W-1:0] sel_cnt;
  logic [EFF_W:0]   cnt_inc;
  logic [EFF_W-1:0] cnt_after;
  logic             full_next;
  logic             window_full_reg;

  always_comb begin
    sel_cnt = '0;
    for (int s = 0; s < NUM_STOCKS; s++) begin
      if (id_ext == 32'(s)) begin
        sel_cnt = cnt_all[s];
      end
    end
  end

  // Saturate at the current window length, which also pulls a count down after a shrink.
  assign cnt_inc   = {1'b0, sel_cnt} + (EFF_W+1)'(1);
  assign cnt_after = (cnt_inc >= {1'b0, eff}) ? eff : EFF_W'(cnt_inc);
  assign full_next = (cnt_after >= eff);

  generate
    for (gi = 0; gi < NUM_STOCKS; gi++) begin : g_fill
      logic [EFF_W-1:0] cnt_reg;

      assign cnt_all[gi] = cnt_reg;

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          cnt_reg <= '0;
        end else if (accept && (id_ext == 32'(gi))) begin
          cnt_reg <= cnt_after;
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      window_full_reg <= 1'b0;
    end else begin
      window_full_reg <= accept && full_next;
    end
  end

  assign o_window_full = window_full_reg;
`endif

endmodule

// File: tb/tb_volatility_ctrl.sv
// Directed bench for volatility_ctrl: base offsets, wrap, interleave, size clamping/shrink, async reset.
module tb_volatility_ctrl;

  localparam int NS = 4;
  localparam int BS = 20;
  localparam int DW = 32;

  logic          i_clk;
  logic          i_reset_n;
  logic [1:0]    i_stock_id;
  logic          i_data_valid;
  logic [DW-1:0] i_buffer_size;
  logic [6:0]    o_write_address;
  logic          o_addr_valid;
`ifdef VOLATILITY_CTRL_FULL_FLAG_EN
  logic          o_window_full;
`endif

  int checks = 0;
  int errors = 0;

  volatility_ctrl #(.NUM_STOCKS(NS), .BUFFER_SIZE(BS), .DATA_WIDTH(DW)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_stock_id     (i_stock_id),
    .i_data_valid   (i_data_valid),
    .i_buffer_size  (i_buffer_size),
    .o_write_address(o_write_address),
`ifdef VOLATILITY_CTRL_FULL_FLAG_EN
    .o_window_full  (o_window_full),
`endif
    .o_addr_valid   (o_addr_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("%s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a strobe now, then check the registered address one edge later.
  task automatic strobe(input string tag, input int id, input int exp_addr);
    i_stock_id   = 2'(id);
    i_data_valid = 1'b1;
    @(posedge i_clk);
    #1;
    $display("strobe %s stock=%0d size=%0d addr=%0d valid=%0b", tag, id, i_buffer_size,
             o_write_address, o_addr_valid);
    check({tag, "_valid"}, 32'(o_addr_valid), 32'd1);
    check({tag, "_addr"}, 32'(o_write_address), 32'(exp_addr));
  endtask

  task automatic idle(input string tag, input int hold_addr);
    i_data_valid = 1'b0;
    @(posedge i_clk);
    #1;
    $display("idle %s addr=%0d valid=%0b", tag, o_write_address, o_addr_valid);
    check({tag, "_valid"}, 32'(o_addr_valid), 32'd0);
    check({tag, "_hold"}, 32'(o_write_address), 32'(hold_addr));
  endtask

  task automatic pulse_reset();
    i_data_valid = 1'b0;
    i_reset_n    = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  initial begin
    i_reset_n     = 1'b0;
    i_stock_id    = 2'd0;
    i_data_valid  = 1'b1;
    i_buffer_size = 32'd20;

    // Strobe held during reset must not register.
    repeat (2) @(posedge i_clk);
    #1;
    $display("reset addr=%0d valid=%0b", o_write_address, o_addr_valid);
    check("rst_valid", 32'(o_addr_valid), 32'd0);
    check("rst_addr", 32'(o_write_address), 32'd0);
    i_data_valid = 1'b0;
    i_reset_n    = 1'b1;

    strobe("first_s0", 0, 0);
    idle("after_first", 0);

    strobe("s2_a", 2, 40);
    strobe("s2_b", 2, 41);
    strobe("s3_a", 3, 60);
    idle("after_base", 60);

    i_buffer_size = 32'd3;
    strobe("wrap0", 1, 20);
    strobe("wrap1", 1, 21);
    strobe("wrap2", 1, 22);
    strobe("wrap3", 1, 20);

    // Reset asserted mid-cycle with a new strobe already on the inputs.
    i_buffer_size = 32'd20;
    i_stock_id    = 2'd2;
    i_data_valid  = 1'b1;
    #2;
    i_reset_n = 1'b0;
    #1;
    $display("async_rst addr=%0d valid=%0b", o_write_address, o_addr_valid);
    check("arst_valid", 32'(o_addr_valid), 32'd0);
    check("arst_addr", 32'(o_write_address), 32'd0);
    @(posedge i_clk);
    #1;
    check("arst_hold_valid", 32'(o_addr_valid), 32'd0);
    i_data_valid = 1'b0;
    i_reset_n    = 1'b1;
    strobe("post_arst_s1", 1, 20);
    idle("post_arst", 20);

    pulse_reset();
    strobe("il0", 0, 0);
    strobe("il1", 1, 20);
    strobe("il2", 0, 1);
    strobe("il3", 1, 21);
    idle("after_il", 21);

    pulse_reset();
    i_buffer_size = 32'd0;
    for (int k = 0; k < 20; k++) strobe("size0", 0, k);
    strobe("size0_wrap", 0, 0);
    i_buffer_size = 32'd100;
    for (int k = 1; k < 20; k++) strobe("size100", 0, k);
    strobe("size100_wrap", 0, 0);

    pulse_reset();
    i_buffer_size = 32'd20;
    for (int k = 0; k < 5; k++) strobe("pre_shrink", 0, k);
    i_buffer_size = 32'd4;
    strobe("shrink0", 0, 0);
    strobe("shrink1", 0, 1);
    strobe("iso_s3", 3, 60);
    strobe("iso_s2", 2, 40);
    idle("end", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
